// File: rtl/string_serializer.sv
// Parallel-to-serial converter with one-word skid buffer; each bit is held DIV clocks
// and a new word can follow the previous one with no idle cycle.
module string_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;

    logic shifting;
    logic div_wrap;
    logic last_bit;
    logic take;

    // Output decode uses only state registers; reset gating keeps data_ready low while held in reset.
    assign shifting   = (state == SHIFT);
    assign div_wrap   = (div_cnt == DW'(DIV - 1));
    assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
    assign data_ready = reset && (!shifting || !hold_full);
    assign take       = data_valid && data_ready;
    assign x          = shifting && ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
    assign x_valid    = shifting && (div_cnt == '0);
    assign busy       = shifting;
    assign word_done  = shifting && last_bit && div_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        shreg   <= data_in;
                        state   <= SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (word_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        if (hold_full) begin
                            shreg     <= hold;
                            hold_full <= 1'b0;
                        end else if (take) begin
                            // Hold is empty, so a word arriving on the last edge goes straight in.
                            shreg <= data_in;
                        end else begin
                            shreg <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        if (take) begin
                            hold      <= data_in;
                            hold_full <= 1'b1;
                        end
                        if (div_wrap) begin
                            div_cnt <= '0;
                            bit_cnt <= bit_cnt + BW'(1);
                            if (MSB_FIRST != 0) begin
                                shreg <= {shreg[WIDTH-2:0], 1'b0};
                            end else begin
                                shreg <= {1'b0, shreg[WIDTH-1:1]};
                            end
                        end else begin
                            div_cnt <= div_cnt + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
